// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param: iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//   per-operation signed/unsigned mode, one operation in flight at a time.
// Latency: accept on edge n -> valid_out high between edges n+WIDTH and n+WIDTH+1
//   (n+ITER and n+ITER+1 with EARLY_TERM_EN); one result per WIDTH+2 cycles back-to-back.
// Backpressure: ready_out low while busy; valid_in without ready_out is dropped, not queued.
//
// Optional feature macro: EARLY_TERM_EN
//   defined   -> stop as soon as the remaining multiplier bits are all zero
//                (iterations = max(1, index of highest set bit of |b| + 1))
//   undefined -> always WIDTH iterations
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset, aborts any operation in flight
//   valid_in   request, accepted on an edge where ready_out=1
//   ready_out  unit idle and not in reset
//   signed_in  1 = two's-complement operands/result, 0 = unsigned (captured at accept)
//   a, b       multiplicand / multiplier (captured at accept)
//   valid_out  one-cycle pulse, r holds the new product
//   r          product register, held until the next completion or reset

module multiplier_iterative_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 valid_out,
    output logic [2*WIDTH-1:0]   r
);

    localparam int PW = 2 * WIDTH;
    // Counter only needs to reach WIDTH-1: the final iteration is detected, not counted past.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("multiplier_iterative_param: WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;   // multiplicand magnitude, shifted left each iteration
    logic [WIDTH-1:0]  mplier_q, mplier_d; // multiplier magnitude, shifted right each iteration
    logic [PW-1:0]     acc_q, acc_d;       // unsigned partial-product accumulator
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;       // result must be negated at completion
    logic [PW-1:0]     r_q, r_d;

    // ------------------------------------------------------------------
    // Operand conditioning at accept time. The magnitude of the most
    // negative value, 2^(WIDTH-1), still fits unsigned in WIDTH bits, so
    // a plain WIDTH-bit two's-complement negate is exact.
    // ------------------------------------------------------------------
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;

    always_comb begin
        a_neg = signed_in & a[WIDTH-1];
        b_neg = signed_in & b[WIDTH-1];
        a_mag = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // ------------------------------------------------------------------
    // Datapath for one iteration. The accumulator is 2*WIDTH bits and the
    // product of two WIDTH-bit magnitudes always fits, so no carry-out is kept.
    // ------------------------------------------------------------------
    logic [PW-1:0]     acc_sum;
    logic [WIDTH-1:0]  mplier_shr;
    logic              last_iter;
    logic [PW-1:0]     r_fix;

    always_comb begin
        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shr = mplier_q >> 1;
`ifdef EARLY_TERM_EN
        // Nothing left to add once the remaining multiplier bits are zero;
        // the first iteration always runs, so b=0 completes in one cycle.
        last_iter  = (cnt_q == CW'(WIDTH - 1)) || (mplier_shr == '0);
`else
        last_iter  = (cnt_q == CW'(WIDTH - 1));
`endif
        r_fix      = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        r_d      = r_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    // r is only written here, so it stays stable throughout RUN.
                    r_d     = r_fix;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // New requests are not looked at here; the unit reopens next cycle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            r_q      <= r_d;
        end
    end

    // ready_out drops combinationally with reset so no request is taken on a reset edge.
    assign ready_out = (state_q == S_IDLE) && !reset;
    assign valid_out = (state_q == S_DONE);
    assign r         = r_q;

endmodule

// File: tb/tb_multiplier_iterative_param.sv
// tb_multiplier_iterative_param: directed vectors against a 32-bit and an 8-bit instance.
// Latency: checks exact accept-to-valid_out edge count, honouring EARLY_TERM_EN when defined.
// Backpressure: checks ready_out low while busy, ignored mid-run requests and reset abort.

module tb_multiplier_iterative_param;

`ifdef EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        vin32, vin8;
    logic        rdy32, rdy8;
    logic        signed_in;
    logic [31:0] a, b;
    logic        vo32, vo8;
    logic [63:0] r32;
    logic [15:0] r8;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int acc_cyc;

    multiplier_iterative_param #(.WIDTH(32)) u_mul32 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (vin32),
        .ready_out (rdy32),
        .signed_in (signed_in),
        .a         (a),
        .b         (b),
        .valid_out (vo32),
        .r         (r32)
    );

    multiplier_iterative_param #(.WIDTH(8)) u_mul8 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (vin8),
        .ready_out (rdy8),
        .signed_in (signed_in),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .valid_out (vo8),
        .r         (r8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_dat(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int full, input int early);
        return ET ? early : full;
    endfunction

    function automatic logic get_vo(input bit w8);
        return w8 ? vo8 : vo32;
    endfunction

    function automatic logic get_rdy(input bit w8);
        return w8 ? rdy8 : rdy32;
    endfunction

    function automatic logic [63:0] get_r(input bit w8);
        return w8 ? {48'd0, r8} : r32;
    endfunction

    // Called #1 after an edge with the selected unit idle; returns #1 after the accept edge.
    task automatic start(input bit w8, input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        signed_in = sgn;
        a = av;
        b = bv;
        if (w8) vin8 = 1'b1;
        else    vin32 = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        vin8  = 1'b0;
        vin32 = 1'b0;
        // Operands may change freely after accept.
        a = '1;
        b = '1;
        signed_in = ~sgn;
        check_dat("busy_after_accept", {63'd0, get_rdy(w8)}, 64'd0);
    endtask

    task automatic wait_done(input bit w8, input logic [63:0] exp_r, input int exp_lat, input string tag);
        logic [63:0] r_before;
        bit seen, r_moved, rdy_seen;
        seen = 0; r_moved = 0; rdy_seen = 0;
        r_before = get_r(w8);
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (get_vo(w8)) seen = 1;
            else begin
                if (get_r(w8) !== r_before) r_moved = 1;
                if (get_rdy(w8)) rdy_seen = 1;
            end
        end
        check_dat({tag, "_seen"}, {63'd0, seen}, 64'd1);
        if (seen) begin
            check_dat({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
            check_dat({tag, "_r"}, get_r(w8), exp_r);
            check_dat({tag, "_r_stable"}, {63'd0, r_moved}, 64'd0);
            check_dat({tag, "_rdy_busy"}, {63'd0, rdy_seen | get_rdy(w8)}, 64'd0);
            @(posedge clk);
            #1;
            check_dat({tag, "_pulse"}, {63'd0, get_vo(w8)}, 64'd0);
            check_dat({tag, "_reidle"}, {63'd0, get_rdy(w8)}, 64'd1);
            check_dat({tag, "_r_hold"}, get_r(w8), exp_r);
        end
    endtask

    task automatic op(input bit w8, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                      input logic [63:0] exp_r, input int exp_lat, input string tag);
        start(w8, sgn, av, bv);
        wait_done(w8, exp_r, exp_lat, tag);
    endtask

    initial begin
        bit vo_flag;
        reset = 1'b1;
        vin32 = 1'b0;
        vin8  = 1'b0;
        signed_in = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_dat("rst_rdy32", {63'd0, rdy32}, 64'd0);
        check_dat("rst_vo32", {63'd0, vo32}, 64'd0);
        check_dat("rst_r32", r32, 64'd0);
        check_dat("rst_r8", {48'd0, r8}, 64'd0);
        reset = 1'b0;
        #1;
        check_dat("rst_rel_rdy32", {63'd0, rdy32}, 64'd1);
        check_dat("rst_rel_rdy8", {63'd0, rdy8}, 64'd1);

        // 32-bit vectors: full latency 32, early-terminate latency from |b|.
        op(0, 0, 32'd7,        32'd6,        64'd42,                 lat(32, 3),  "u7x6");
        op(0, 1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFFFFFFFFF1,   lat(32, 3),  "sm3x5");
        op(0, 0, 32'hFFFFFFFD, 32'd5,        64'h00000004FFFFFFF1,   lat(32, 3),  "uFFFDx5");
        op(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001,   lat(32, 32), "umax");
        op(0, 1, 32'h80000000, 32'h80000000, 64'h4000000000000000,   lat(32, 32), "smin");
        op(0, 1, 32'd5,        32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFF1,   lat(32, 2),  "s5xm3");
        op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1,                  lat(32, 1),  "sm1xm1");
        op(0, 0, 32'd0,        32'd0,        64'd0,                  lat(32, 1),  "zero");
        op(0, 0, 32'd123,      32'd1,        64'd123,                lat(32, 1),  "b1");
        op(0, 0, 32'd2,        32'h80000000, 64'h0000000100000000,   lat(32, 32), "bmsb");

        // 8-bit instance.
        op(1, 1, 32'h80, 32'hFF, 64'h0080, lat(8, 1), "w8_sm128xm1");
        op(1, 0, 32'hFF, 32'hFF, 64'hFE01, lat(8, 8), "w8_umax");
        op(1, 1, 32'h7F, 32'h80, 64'hC080, lat(8, 8), "w8_s127xm128");

        // Request while busy is dropped.
        start(0, 0, 32'd2, 32'd3);
        a = 32'd9;
        b = 32'd9;
        vin32 = 1'b1;
        @(posedge clk);
        #1;
        vin32 = 1'b0;
        wait_done(0, 64'd6, lat(32, 2), "busy_ign");

        // Reset mid-run aborts: no valid_out, r cleared, idle once reset drops.
        start(0, 0, 32'd5, 32'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_dat("abort_vo", {63'd0, vo32}, 64'd0);
        check_dat("abort_r", r32, 64'd0);
        check_dat("abort_rdy_in_rst", {63'd0, rdy32}, 64'd0);
        reset = 1'b0;
        #1;
        check_dat("abort_rdy", {63'd0, rdy32}, 64'd1);
        vo_flag = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (vo32) vo_flag = 1;
        end
        check_dat("abort_no_vo", {63'd0, vo_flag}, 64'd0);
        check_dat("abort_r_held", r32, 64'd0);
        op(0, 0, 32'd4, 32'd4, 64'd16, lat(32, 3), "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multiplier_iterative_param.md
Name: multiplier_iterative_param

Overview:
Parametrised successor to the fixed 32-bit iterative multiplier: shift-and-add, one multiplier bit per cycle, WIDTH x WIDTH -> 2*WIDTH product. Adds a per-operation signed/unsigned mode, an explicit ready handshake, and synchronous reset with abort. Used as the multi-cycle MUL/MULT functional unit behind the ISA datapath; one operation in flight at a time.

Parameters:
WIDTH, 32, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; aborts any operation.
valid_in  input  1  request; accepted only on an edge where ready_out=1.
ready_out  output  1  unit idle, can accept a request this cycle.
signed_in  input  1  1 = two's-complement operands/result, 0 = unsigned; captured at accept.
a  input  WIDTH  multiplicand; captured at accept.
b  input  WIDTH  multiplier; captured at accept.
valid_out  output  1  single-cycle pulse, r holds new product.
r  output  2*WIDTH  product register.

Behaviour:
- Reset (sync, active-high): state IDLE, valid_out=0, r=0, counter=0. ready_out = (state==IDLE) && !reset. Reset during RUN/DONE discards the operation; no valid_out for it.
- States: IDLE, RUN, DONE.
- IDLE: ready_out=1. Edge with valid_in=1 -> latch magnitudes |a|, |b| (raw values when signed_in=0), result sign = signed_in & (a[MSB]^b[MSB]), clear accumulator and counter, go RUN.
- RUN: ready_out=0. Each edge: if multiplier LSB=1, add shifted multiplicand into 2*WIDTH accumulator; shift multiplier right, multiplicand left; counter++. The edge completing iteration WIDTH writes r = sign ? -acc : acc (2*WIDTH two's complement) and goes DONE.
- DONE: valid_out=1 for exactly this one cycle; next edge -> IDLE. valid_in in DONE is ignored.
- Latency: accept on edge n -> valid_out high between edges n+WIDTH and n+WIDTH+1. Back-to-back throughput: one result per WIDTH+2 cycles.
- r holds its value until the next completing edge or reset; it does not change during RUN.
- valid_in while ready_out=0 is ignored (not queued). Changes to a/b/signed_in after accept have no effect.
- Width rules: magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable unsigned in WIDTH bits; accumulator 2*WIDTH bits never overflows (max 2^(2*WIDTH-2) signed, (2^WIDTH-1)^2 unsigned).
- Zero operands take full latency (without optional feature).

Optional Feature:
EARLY_TERM_EN
- Defined: in RUN, if the remaining shifted multiplier is zero, write r (with sign fix) and go DONE on that edge. Iterations = max(1, index of highest set bit of |b| + 1). Result identical to full run; latency = iterations instead of WIDTH. b=0 -> valid_out high between edges n+1 and n+2.
- Undefined: always WIDTH iterations; latency fixed as above.

Test Plan:
- WIDTH=32, unsigned, a=7, b=6, accept on edge n -> valid_out high only between edges n+32 and n+33, r=64'd42; ready_out low from n to n+33.
- WIDTH=32, signed, a=-3 (32'hFFFFFFFD), b=5 -> r=64'hFFFFFFFFFFFFFFF1; unsigned same inputs -> r=64'h00000004FFFFFFF1.
- WIDTH=32, unsigned 32'hFFFFFFFF x 32'hFFFFFFFF -> r=64'hFFFFFFFE00000001; signed 32'h80000000 x 32'h80000000 -> r=64'h4000000000000000.
- WIDTH=8 instance: signed 8'h80 x 8'hFF (-128 x -1) -> r=16'h0080; unsigned 8'hFF x 8'hFF -> r=16'hFE01; valid_out high between edges n+8 and n+9.
- Busy/abort: accept a=2,b=3; pulse valid_in with a=9,b=9 mid-RUN -> ignored, r=6. Next op a=5,b=5, reset high one edge mid-RUN -> no valid_out, r=0, ready_out=1 cycle after reset drops; fresh a=4,b=4 -> r=16.
- EARLY_TERM_EN defined, WIDTH=32: b=1, a=123 -> valid_out high between edges n+1 and n+2, r=123; b=32'h80000000 unsigned, a=2 -> 32 iterations, r=64'h100000000.
